// File: rtl/huffman_code_builder.sv
// huffman_code_builder
// ---------------------------------------------------------------------------
// Builds the Huffman code table for six symbols from the merge pairs emitted
// by the upstream 2-of-6 minimum finder. Each accepted pair prepends one code
// bit to every symbol named in its masks. Symbols in the smaller entry get a
// 1 and symbols in the larger entry get a 0. After ROUNDS pairs the table is
// complete and done pulses once.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             pulse: clear the table and begin collecting pairs
//   pair_valid        pair_hi/pair_lo carry a merge result this cycle
//   pair_hi, pair_lo  {count[14:7], flag[6], symbol mask[5:0]}; the mask is used
//   pair_ready        high while collecting; accept = pair_valid && pair_ready
//   done              one-cycle pulse after the final pair is absorbed
//   busy              high while collecting
//   err               sticky pair-consistency error (optional feature)
//   HC1..HC6          right-aligned code words; the LSB is the leaf-level bit
//   M1..M6            right-aligned valid-bit masks (code length in ones)
//
// Optional feature: define HUFF_PAIR_CHECK_EN to enable the pair consistency
// checker that drives err. Without it, err is tied low.
// ---------------------------------------------------------------------------
module huffman_code_builder #(
  parameter int CODE_W = 8,
  parameter int ROUNDS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pair_valid,
  input  logic [14:0]       pair_hi,
  input  logic [14:0]       pair_lo,
  output logic              pair_ready,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [CODE_W-1:0] HC1, HC2, HC3, HC4, HC5, HC6,
  output logic [CODE_W-1:0] M1, M2, M3, M4, M5, M6
);

  localparam int CNT_W = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  round_cnt;
  logic [CODE_W-1:0] hc [6];
  logic [CODE_W-1:0] m  [6];
  logic [CODE_W-1:0] hc_nxt [6];
  logic [CODE_W-1:0] m_nxt  [6];
  logic [5:0]        sel;
  logic [5:0]        sat;
  logic              accept;
  logic              unused_fields;

  // The count and flag fields are produced upstream but carry nothing this
  // block needs.
  assign unused_fields = ^{pair_hi[14:6], pair_lo[14:6]};

  // start has priority over a pair, so a pair arriving together with start
  // is dropped.
  assign accept = (state == COLLECT) && pair_valid && !start;

  // Per-symbol next table entry. Masks are always right-aligned runs of
  // ones, so the bit one position above the run marks the next free code bit
  // (index = popcount of the mask). A saturated mask leaves the entry alone.
  // If a symbol appears in both masks, the larger entry (a 0 bit) wins.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      hc_nxt[i] = hc[i];
      m_nxt[i]  = m[i];
      sel[i]    = pair_lo[i] | pair_hi[i];
      sat[i]    = &m[i];
      if (sel[i] && !sat[i]) begin
        m_nxt[i] = {m[i][CODE_W-2:0], 1'b1};
        if (pair_hi[i])
          hc_nxt[i] = hc[i] & ~(m_nxt[i] & ~m[i]);
        else
          hc_nxt[i] = hc[i] | (m_nxt[i] & ~m[i]);
      end
    end
  end

  // Control FSM and table registers. done, busy and pair_ready are
  // registered alongside the state so they line up with it exactly. A start
  // in any state clears the table and (re)enters COLLECT. done still pulses
  // in a DONE cycle that also sees start, because it was set on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      round_cnt  <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      pair_ready <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        hc[i] <= '0;
        m[i]  <= '0;
      end
    end else begin
      done <= 1'b0;
      if (start) begin
        state      <= COLLECT;
        round_cnt  <= '0;
        busy       <= 1'b1;
        pair_ready <= 1'b1;
        for (int i = 0; i < 6; i++) begin
          hc[i] <= '0;
          m[i]  <= '0;
        end
      end else begin
        case (state)
          COLLECT: begin
            if (pair_valid) begin
              for (int i = 0; i < 6; i++) begin
                hc[i] <= hc_nxt[i];
                m[i]  <= m_nxt[i];
              end
              round_cnt <= round_cnt + 1'b1;
              if (round_cnt == CNT_W'(ROUNDS - 1)) begin
                state      <= DONE;
                busy       <= 1'b0;
                pair_ready <= 1'b0;
                done       <= 1'b1;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef HUFF_PAIR_CHECK_EN
  logic pair_bad;

  // A well-formed pair has two non-empty, disjoint masks and never selects a
  // symbol whose code is already at full length.
  assign pair_bad = ((pair_hi[5:0] & pair_lo[5:0]) != 6'd0) ||
                    (pair_hi[5:0] == 6'd0) || (pair_lo[5:0] == 6'd0) ||
                    ((sel & sat) != 6'd0);

  // err is sticky until the next start or reset.
  always_ff @(posedge clk) begin
    if (reset)
      err <= 1'b0;
    else if (start)
      err <= 1'b0;
    else if (accept && pair_bad)
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

  assign HC1 = hc[0];
  assign HC2 = hc[1];
  assign HC3 = hc[2];
  assign HC4 = hc[3];
  assign HC5 = hc[4];
  assign HC6 = hc[5];
  assign M1  = m[0];
  assign M2  = m[1];
  assign M3  = m[2];
  assign M4  = m[3];
  assign M5  = m[4];
  assign M6  = m[5];

endmodule

// File: tb/tb_huffman_code_builder.sv
// tb_huffman_code_builder
// ---------------------------------------------------------------------------
// Directed bench for huffman_code_builder. Each stimulus step queues a
// hand-computed expected snapshot ({HC6..HC1}, {M6..M1}, busy, pair_ready,
// done, err) tagged with the cycle it becomes due. An independent monitor
// compares the snapshot against the DUT on the falling edge of that cycle.
// ---------------------------------------------------------------------------
module tb_huffman_code_builder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        pair_valid = 1'b0;
   logic [14:0] pair_hi = '0;
   logic [14:0] pair_lo = '0;
   logic        pair_ready, done, busy, err;
   logic [7:0]  HC1, HC2, HC3, HC4, HC5, HC6;
   logic [7:0]  M1, M2, M3, M4, M5, M6;

   huffman_code_builder #(.CODE_W(8), .ROUNDS(5)) dut (
      .clk(clk), .reset(reset), .start(start), .pair_valid(pair_valid),
      .pair_hi(pair_hi), .pair_lo(pair_lo), .pair_ready(pair_ready),
      .done(done), .busy(busy), .err(err),
      .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
      .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   int cyc = 0;

   // Cycle count that tags when each expected snapshot becomes due.
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      int          due;
      logic        chk_tbl;
      logic [47:0] hc;
      logic [47:0] m;
      logic        busy;
      logic        ready;
      logic        done;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_vec  = 0;
   int   n_fail = 0;
   logic exp_err = 1'b0;

   // Skewed tree: lo masks 01,03,07,0F,1F and hi masks 02,04,08,10,20.
   logic [14:0] lo_tab [5] = '{15'h0101, 15'h0283, 15'h0107, 15'h010F, 15'h011F};
   logic [14:0] hi_tab [5] = '{15'h0182, 15'h0304, 15'h0108, 15'h0110, 15'h0120};
   logic [47:0] hc_tab [5] = '{48'h0000_0000_0001, 48'h0000_0000_0203,
                               48'h0000_0002_0607, 48'h0000_0206_0E0F,
                               48'h0002_060E_1E1F};
   logic [47:0] m_tab  [5] = '{48'h0000_0000_0101, 48'h0000_0001_0303,
                               48'h0000_0103_0707, 48'h0001_0307_0F0F,
                               48'h0103_070F_1F1F};

   // Monitor: compares every snapshot that has come due against the DUT.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         logic ok;
         logic [47:0] act_hc, act_m;
         e      = sb.pop_front();
         act_hc = {HC6, HC5, HC4, HC3, HC2, HC1};
         act_m  = {M6, M5, M4, M3, M2, M1};
         n_vec++;
         ok = (e.due == cyc) && (busy === e.busy) && (pair_ready === e.ready) &&
              (done === e.done) && (err === e.err);
         if (e.chk_tbl)
            ok = ok && (act_hc === e.hc) && (act_m === e.m);
         if (!ok) begin
            n_fail++;
            $display("[TB] FAIL %s (due %0d at %0d): got hc=%h m=%h busy=%b ready=%b done=%b err=%b, expected hc=%h m=%h busy=%b ready=%b done=%b err=%b (table checked=%b)",
                     e.name, e.due, cyc, act_hc, act_m, busy, pair_ready, done, err,
                     e.hc, e.m, e.busy, e.ready, e.done, e.err, e.chk_tbl);
         end
      end
   end

   // Drives one cycle of inputs, lets the edge happen, then idles the inputs.
   task automatic applyStimulus(input logic r, input logic st, input logic pv,
                                input logic [14:0] lo, input logic [14:0] hi);
      reset      = r;
      start      = st;
      pair_valid = pv;
      pair_lo    = lo;
      pair_hi    = hi;
      @(posedge clk);
      #1;
      reset      = 1'b0;
      start      = 1'b0;
      pair_valid = 1'b0;
      pair_lo    = '0;
      pair_hi    = '0;
   endtask

   // Queues the expected state for the cycle just entered.
   task automatic checkOutput(input string name, input logic chk,
                              input logic [47:0] hc, input logic [47:0] m,
                              input logic b, input logic rd, input logic d,
                              input logic er);
      exp_t x;
      x.name = name; x.due = cyc; x.chk_tbl = chk; x.hc = hc; x.m = m;
      x.busy = b; x.ready = rd; x.done = d; x.err = er;
      sb.push_back(x);
   endtask

   // Feeds the first n pairs of the skewed tree; the fifth completes it.
   task automatic runRounds(input int n);
      for (int r = 0; r < n; r++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, lo_tab[r], hi_tab[r]);
         checkOutput($sformatf("round%0d", r + 1), 1'b1, hc_tab[r], m_tab[r],
                     r != 4, r != 4, r == 4, 1'b0);
      end
   endtask

   // Main directed sequence, followed by direct checks of the final restart
   // and a sweep for any snapshot that never came due.
   initial begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      checkOutput("reset", 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
      checkOutput("start", 1'b1, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      runRounds(5);
      applyStimulus(1'b0, 1'b0, 1'b1, 15'h0101, 15'h0102);
      checkOutput("idle_ignore", 1'b1, hc_tab[4], m_tab[4], 1'b0, 1'b0, 1'b0, 1'b0);

      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
      checkOutput("start2", 1'b1, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      runRounds(2);
      applyStimulus(1'b0, 1'b1, 1'b1, lo_tab[2], hi_tab[2]);
      checkOutput("restart_drop", 1'b1, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      runRounds(5);

      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
      runRounds(1);
      applyStimulus(1'b1, 1'b0, 1'b1, lo_tab[1], hi_tab[1]);
      checkOutput("reset_mid", 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, lo_tab[0], hi_tab[0]);
      checkOutput("post_reset_ignore", 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef HUFF_PAIR_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
      checkOutput("err_start", 1'b1, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 15'h0103, 15'h0102);
      checkOutput("err_overlap", 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, exp_err);
      applyStimulus(1'b0, 1'b0, 1'b1, 15'h0104, 15'h0108);
      checkOutput("err_r2", 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, exp_err);
      applyStimulus(1'b0, 1'b0, 1'b1, 15'h0110, 15'h0120);
      checkOutput("err_r3", 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, exp_err);
      applyStimulus(1'b0, 1'b0, 1'b1, 15'h0101, 15'h0102);
      checkOutput("err_r4", 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, exp_err);
      applyStimulus(1'b0, 1'b0, 1'b1, 15'h0104, 15'h0108);
      checkOutput("err_done", 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, exp_err);

      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
      checkOutput("start_in_done", 1'b1, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);

      n_vec++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL direct busy after start in DONE: got %b", busy);
      end
      n_vec++;
      if (pair_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL direct pair_ready after start in DONE: got %b", pair_ready);
      end
      n_vec++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL direct done after start in DONE: got %b", done);
      end
      n_vec++;
      if ({M6, M5, M4, M3, M2, M1} !== 48'h0) begin
         n_fail++;
         $display("[TB] FAIL direct masks after start in DONE: got %h", {M6, M5, M4, M3, M2, M1});
      end
      n_vec++;
      if ({HC6, HC5, HC4, HC3, HC2, HC1} !== 48'h0) begin
         n_fail++;
         $display("[TB] FAIL direct codes after start in DONE: got %h", {HC6, HC5, HC4, HC3, HC2, HC1});
      end

      repeat (2) @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_vec++;
         n_fail++;
         $display("[TB] FAIL %s: never compared, due at cycle %0d, run ended at %0d", e.name, e.due, cyc);
      end
      $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/huffman_code_builder.md
Name: huffman_code_builder

Overview:
- Sequential stage directly downstream of the 2-of-6 minimum-finder PE in the Huffman coder.
- Each merge round, the PE emits the two smallest entries (larger-min, smaller-min). Each entry is 15 bits: count[14:7], flag[6], symbol mask[5:0].
- This block consumes one such pair per round over 5 rounds. It prepends one code bit to every symbol in each mask, building code words HC1..HC6 and valid-bit masks M1..M6 for symbols 1..6.

Parameters:
- CODE_W, 8, width of each code word and mask register (max code length for 6 symbols is 5, so 8 is ample).
- ROUNDS, 5, number of merge pairs per table (NSYM-1 for 6 symbols).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; clears the table and begins collecting.
- pair_valid  in  1  pair_hi/pair_lo hold a merge result this cycle.
- pair_hi  in  15  larger of the two minima (PE CNT5_n).
- pair_lo  in  15  smaller of the two minima (PE CNT6_n).
- pair_ready  out  1  high while in COLLECT; a pair is accepted when pair_valid && pair_ready.
- done  out  1  one-cycle pulse after the final pair is absorbed.
- busy  out  1  high in COLLECT.
- err  out  1  sticky error flag (see Optional Feature).
- HC1..HC6  out  CODE_W each  code words, right-aligned; LSB is the first-assigned (leaf-level) bit.
- M1..M6  out  CODE_W each  valid-bit masks, right-aligned ones, width = code length.

Behaviour:
- Reset values:
  - State = IDLE.
  - All HCi, Mi, the round counter, done, busy, pair_ready and err = 0.
- States:
  - IDLE:
    - pair_ready=0.
    - start -> COLLECT. Entering COLLECT clears all HCi, Mi, the round counter and err.
  - COLLECT:
    - pair_ready=1, busy=1.
    - On accept:
      - For i=1..6, let len_i = popcount(Mi).
      - If pair_lo[i-1]=1: HCi[len_i] <= 1, Mi <= {Mi[CODE_W-2:0],1}.
      - If pair_hi[i-1]=1: HCi[len_i] <= 0, Mi <= {Mi[CODE_W-2:0],1}.
      - Symbols in neither mask are unchanged.
      - Round counter +1.
    - When the accepted pair is round ROUNDS (counter = ROUNDS-1 before the increment) -> DONE.
  - DONE:
    - done=1 for exactly this one cycle; pair_ready=0.
    - Next state is IDLE.
    - HCi/Mi hold until the next start.
- Latency: the HC/M update is visible the cycle after acceptance. done asserts the cycle after the 5th accept.
- Masks are updated independently per symbol, so all six update in parallel in a single cycle.
- Count fields [14:7] and flag [6] are ignored by this block.
- pair_valid in IDLE or DONE is ignored, with no state change.
- start in COLLECT restarts: clear and remain in COLLECT; the round counter goes to 0.
- start and pair_valid in the same cycle: start wins and the pair is dropped.
- start in the DONE cycle: go to COLLECT with a cleared table; done still pulses that cycle.
- Code length saturation: if Mi is all ones when its symbol is selected, HCi and Mi are not modified.
- Reset mid-operation returns everything to the reset values on the next edge, regardless of state.

Optional Feature:
- Macro: HUFF_PAIR_CHECK_EN.
- When defined, on each accepted pair err is set (sticky until start or reset) if any of these hold:
  - (pair_hi[5:0] & pair_lo[5:0]) != 0;
  - pair_hi[5:0]==0 or pair_lo[5:0]==0;
  - a selected symbol's Mi is already saturated.
- The update still proceeds per the rules above.
- When not defined, err is tied to 0 and no check logic is synthesized.

Test Plan:
- Reset, then start, then pair lo=15'h0101, hi=15'h0182 -> next cycle HC1=8'h01, M1=8'h01, HC2=8'h00, M2=8'h01; all other HC/M = 0; busy=1.
- Continue with pair lo=15'h0283, hi=15'h0304 -> HC1=8'h03, M1=8'h03, HC2=8'h02, M2=8'h03, HC3=8'h00, M3=8'h01.
- Complete 5 rounds for a skewed tree, with lo masks 01,03,07,0F,1F and hi masks 02,04,08,10,20 ->
  - done pulses one cycle after the 5th accept;
  - M1=M2=8'h1F, M6=8'h01, HC1=8'h1F, HC6=8'h00;
  - state then IDLE with pair_ready=0.
- Assert start together with pair_valid in mid-COLLECT (round 3) -> pair dropped, all HC/M = 0, round counter 0, pair_ready stays 1.
- Assert reset during round 2 -> all outputs 0 the next cycle; pair_valid is then ignored until start.
- With HUFF_PAIR_CHECK_EN: pair lo=15'h0103, hi=15'h0102 (overlap on bit 1) -> err=1 and stays 1 through done; the next start clears it. Without the macro, err=0 throughout.
